// File: rtl/rot_sequencer_if.sv
// rot_sequencer_if: request, rotator and result signals of the multi-step rotate controller
interface rot_sequencer_if #(
  parameter int WIDTH  = 7,
  parameter int STEP_W = 3
);
  logic              start_valid;
  logic              start_ready;
  logic [WIDTH-1:0]  a_in;
  logic [1:0]        dir;
  logic [STEP_W-1:0] steps;
  logic [WIDTH-1:0]  sh_a;
  logic [1:0]        sh_op;
  logic [WIDTH-1:0]  sh_result;
  logic              res_valid;
  logic              res_ready;
  logic [WIDTH-1:0]  res_data;
  logic              busy;

  // Environment side: requester, downstream rotator and result consumer
  modport master (
    output start_valid, a_in, dir, steps, sh_result, res_ready,
    input  start_ready, sh_a, sh_op, res_valid, res_data, busy
  );

  // Sequencer side
  modport slave (
    input  start_valid, a_in, dir, steps, sh_result, res_ready,
    output start_ready, sh_a, sh_op, res_valid, res_data, busy
  );
endinterface

// File: rtl/rot_sequencer.sv
// rot_sequencer: iterates a single-step rotator to perform 0..7 rotations of a 7-bit operand
module rot_sequencer #(
  parameter int WIDTH  = 7,
  parameter int STEP_W = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  rot_sequencer_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ROTATE = 2'd1, S_DONE = 2'd2} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [WIDTH-1:0]  r_areg;
  logic [1:0]        r_dreg;
  logic [STEP_W-1:0] r_cnt;
  logic [1:0]        w_dir;
  logic              w_accept;
  logic              w_last;

  // A zero step count is folded into the stored direction so that r_dreg == 00
  // uniformly marks a pass-through request.
  assign w_dir    = (bus.dir == 2'b11 || bus.steps == '0) ? 2'b00 : bus.dir;
  assign w_accept = (r_state == S_IDLE) && bus.start_valid;
  // Pass-through requests spend exactly one non-rotating ROTATE cycle, which keeps
  // their result one edge after acceptance like a single-step rotation.
  assign w_last   = (r_cnt == STEP_W'(1)) || (r_dreg == 2'b00);

  assign bus.sh_a     = r_areg;
  assign bus.res_data = r_areg;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and handshake/rotator control outputs
  always_comb begin
    w_next          = r_state;
    bus.start_ready = 1'b0;
    bus.res_valid   = 1'b0;
    bus.busy        = 1'b1;
    bus.sh_op       = 2'b00;
    case (r_state)
      S_IDLE: begin
        bus.start_ready = 1'b1;
        bus.busy        = 1'b0;
        w_next          = bus.start_valid ? S_ROTATE : S_IDLE;
      end
      S_ROTATE: begin
        bus.sh_op = r_dreg;
        w_next    = w_last ? S_DONE : S_ROTATE;
      end
      S_DONE: begin
        bus.res_valid = 1'b1;
        w_next        = bus.res_ready ? S_IDLE : S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operand/direction/count: latch on acceptance, then feed the rotator output back each cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_areg <= '0;
      r_dreg <= 2'b00;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_areg <= bus.a_in;
      r_dreg <= w_dir;
      r_cnt  <= bus.steps;
    end else if (r_state == S_ROTATE && r_dreg != 2'b00) begin
      r_areg <= bus.sh_result;
      r_cnt  <= r_cnt - STEP_W'(1);
    end
  end
endmodule

// File: tb/tb_rot_sequencer.sv
// tb_rot_sequencer: randomized and directed checks of rot_sequencer against an arithmetic rotation model
module tb_rot_sequencer;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_hs  = 0;
  int   n_req = 0;

  rot_sequencer_if bus ();

  rot_sequencer dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Downstream single-step rotator
  assign bus.sh_result = (bus.sh_op == 2'b01) ? {bus.sh_a[0], bus.sh_a[6:1]} :
                         (bus.sh_op == 2'b10) ? {bus.sh_a[5:0], bus.sh_a[6]} : bus.sh_a;

  // Count completed result handshakes
  always @(posedge clk) if (rst_n && bus.res_valid && bus.res_ready) n_hs++;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] rot(input logic [6:0] a, input logic [1:0] d, input int n);
    int v, k, r;
    v = int'(a);
    k = n % 7;
    r = (d == 2'b01) ? ((v >> k) | (v << (7 - k))) :
        (d == 2'b10) ? ((v << k) | (v >> (7 - k))) : v;
    return 7'(r & 127);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start_ready"}, bus.start_ready, 1);
    check({tag, "_res_valid"}, bus.res_valid, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_res_data"}, bus.res_data, 0);
    check({tag, "_sh_a"}, bus.sh_a, 0);
    check({tag, "_sh_op"}, bus.sh_op, 0);
  endtask

  task automatic junk;
    bus.start_valid = 1'($urandom);
    bus.a_in        = 7'($urandom);
    bus.dir         = 2'($urandom);
    bus.steps       = 3'($urandom);
  endtask

  // One request from acceptance to result handshake; hold keeps start_valid and inputs steady
  task automatic run_req(input logic [6:0] a, input logic [1:0] d, input logic [2:0] s,
                         input int stall, input bit hold);
    logic [1:0] dn;
    logic [6:0] exp;
    int         lat;
    dn  = (d == 2'b11 || s == 3'd0) ? 2'b00 : d;
    lat = (dn == 2'b00) ? 1 : int'(s);
    exp = rot(a, dn, int'(s));
    bus.a_in        = a;
    bus.dir         = d;
    bus.steps       = s;
    bus.start_valid = 1'b1;
    bus.res_ready   = 1'b0;
    check("start_ready_idle", bus.start_ready, 1);
    tick;
    n_req++;
    for (int j = 0; j < lat; j++) begin
      if (!hold) junk();
      check("busy_rot", bus.busy, 1);
      check("res_valid_rot", bus.res_valid, 0);
      check("start_ready_rot", bus.start_ready, 0);
      check("sh_op_rot", bus.sh_op, dn);
      check("sh_a_rot", bus.sh_a, rot(a, dn, j));
      tick;
    end
    check("res_valid_done", bus.res_valid, 1);
    check("res_data_done", bus.res_data, exp);
    check("sh_op_done", bus.sh_op, 0);
    for (int j = 0; j < stall; j++) begin
      if (!hold) junk();
      tick;
      check("res_valid_stall", bus.res_valid, 1);
      check("res_data_stall", bus.res_data, exp);
      check("start_ready_stall", bus.start_ready, 0);
    end
    bus.res_ready = 1'b1;
    if (!hold) bus.start_valid = 1'b0;
    tick;
    bus.res_ready = 1'b0;
    check("start_ready_after", bus.start_ready, 1);
    check("res_valid_after", bus.res_valid, 0);
    check("busy_after", bus.busy, 0);
    check("res_data_kept", bus.res_data, exp);
    check("handshake_count", n_hs, n_req);
  endtask

  initial begin
    bus.start_valid = 1'b0;
    bus.res_ready   = 1'b0;
    bus.a_in        = '0;
    bus.dir         = 2'b00;
    bus.steps       = '0;
    #2;
    check_reset_outputs("por");
    #6 rst_n = 1'b1;
    check_reset_outputs("por_rel");

    // Directed cases
    run_req(7'b1010110, 2'b01, 3'd1, 0, 1'b0);
    run_req(7'b1010110, 2'b10, 3'd3, 4, 1'b0);
    run_req(7'b1010110, 2'b01, 3'd7, 1, 1'b0);
    run_req(7'b1010110, 2'b11, 3'd5, 2, 1'b0);
    run_req(7'b0110011, 2'b10, 3'd0, 0, 1'b0);
    run_req(7'b0110011, 2'b00, 3'd4, 0, 1'b0);

    // Back-to-back with start_valid held high
    run_req(7'b0000001, 2'b10, 3'd2, 0, 1'b1);
    run_req(7'b1000000, 2'b01, 3'd1, 0, 1'b0);

    // Asynchronous reset in the middle of a rotation
    bus.a_in        = 7'b1010110;
    bus.dir         = 2'b01;
    bus.steps       = 3'd5;
    bus.start_valid = 1'b1;
    tick;
    bus.start_valid = 1'b0;
    tick;
    tick;
    check("mid_rot_sh_a", bus.sh_a, rot(7'b1010110, 2'b01, 2));
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    tick;
    tick;
    check_reset_outputs("rst_hold");
    #3 rst_n = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick;
      check_reset_outputs("rst_rel");
    end
    check("no_result_after_abort", n_hs, n_req);
    run_req(7'b1010110, 2'b01, 3'd1, 0, 1'b0);

    // Randomized requests with random backpressure
    for (int i = 0; i < 60; i++)
      run_req(7'($urandom), 2'($urandom), 3'($urandom), int'($urandom_range(0, 4)), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
